// File: rtl/path_run_sequencer.sv
// path_run_sequencer: top-level run controller for the path-counting engine.
// Issues one engine run (Part 1: you->out) or six segment runs (Part 2) and
// combines the returned counts into
//   part2 = svr->fft * fft->dac * dac->out + svr->dac * dac->fft * fft->out.
// Optional feature macro: SEG_SKIP_ZERO_EN -- when defined, a zero count in
// the middle of a Part 2 chain ends that chain early without launching its
// remaining segments. The answer is identical either way.
module path_run_sequencer #(
  parameter int PARAM_NODE_IDX_WIDTH  = 10,
  parameter int PARAM_ACCUM_VAL_WIDTH = 24,
  parameter int PARAM_PROD_VAL_WIDTH  = 49
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             part_sel,
  input  logic                             start_run,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]  cfg_you_idx,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]  cfg_svr_idx,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]  cfg_out_idx,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]  cfg_dac_idx,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]  cfg_fft_idx,
  output logic                             eng_start,
  output logic [PARAM_NODE_IDX_WIDTH-1:0]  eng_src_idx,
  output logic [PARAM_NODE_IDX_WIDTH-1:0]  eng_dst_idx,
  input  logic                             eng_done,
  input  logic [PARAM_ACCUM_VAL_WIDTH-1:0] eng_count,
  output logic                             busy,
  output logic [PARAM_ACCUM_VAL_WIDTH-1:0] part1_ans,
  output logic [PARAM_PROD_VAL_WIDTH-1:0]  part2_ans,
  output logic                             done_reg
);

  localparam int NW = PARAM_NODE_IDX_WIDTH;
  localparam int AW = PARAM_ACCUM_VAL_WIDTH;
  localparam int PW = PARAM_PROD_VAL_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_MUL,
    S_ACC,
    S_DONE
  } state_t;

  state_t         state;
  logic           part_q;     // latched part: 0 = Part 1, 1 = Part 2
  logic [2:0]     seg;        // current segment index
  logic [AW-1:0]  count_q;    // engine count captured on eng_done
  logic [PW-1:0]  prod;       // running product of the current chain
  logic [PW-1:0]  sum;        // sum of completed chains
  logic [PW-1:0]  mul_res;

  // Segment table: source node for a given part/segment.
  function automatic logic [NW-1:0] seg_src(input logic p, input logic [2:0] s);
    if (!p) return cfg_you_idx;
    case (s)
      3'd0:    return cfg_svr_idx;
      3'd1:    return cfg_fft_idx;
      3'd2:    return cfg_dac_idx;
      3'd3:    return cfg_svr_idx;
      3'd4:    return cfg_dac_idx;
      default: return cfg_fft_idx;
    endcase
  endfunction

  // Segment table: destination node for a given part/segment.
  function automatic logic [NW-1:0] seg_dst(input logic p, input logic [2:0] s);
    if (!p) return cfg_out_idx;
    case (s)
      3'd0:    return cfg_fft_idx;
      3'd1:    return cfg_dac_idx;
      3'd2:    return cfg_out_idx;
      3'd3:    return cfg_dac_idx;
      3'd4:    return cfg_fft_idx;
      default: return cfg_out_idx;
    endcase
  endfunction

  // Single shared multiplier, product truncated to the product width.
  always_comb mul_res = prod * {{(PW-AW){1'b0}}, count_q};

  // Run controller: sequences segments and owns every registered output.
  // NOTE: all state here uses non-blocking assignments so every register
  // sees the pre-edge value of the others, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      part_q      <= 1'b0;
      seg         <= 3'd0;
      count_q     <= '0;
      prod        <= {{(PW-1){1'b0}}, 1'b1};
      sum         <= '0;
      eng_start   <= 1'b0;
      eng_src_idx <= '0;
      eng_dst_idx <= '0;
      busy        <= 1'b0;
      part1_ans   <= '0;
      part2_ans   <= '0;
      done_reg    <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start_run) begin
            part_q      <= part_sel;
            prod        <= {{(PW-1){1'b0}}, 1'b1};
            sum         <= '0;
            seg         <= 3'd0;
            done_reg    <= 1'b0;
            busy        <= 1'b1;
            eng_start   <= 1'b1;
            eng_src_idx <= seg_src(part_sel, 3'd0);
            eng_dst_idx <= seg_dst(part_sel, 3'd0);
            state       <= S_LAUNCH;
          end
        end
        S_LAUNCH: state <= S_WAIT;
        S_WAIT: begin
          if (eng_done) begin
            count_q <= eng_count;
            state   <= S_MUL;
          end
        end
        S_MUL: begin
          prod <= mul_res;
          if (!part_q) begin
            part1_ans <= count_q;
            busy      <= 1'b0;
            done_reg  <= 1'b1;
            state     <= S_DONE;
          end else if (seg == 3'd2 || seg == 3'd5) begin
            state <= S_ACC;
`ifdef SEG_SKIP_ZERO_EN
          end else if (count_q == '0) begin
            // A zero factor kills the chain; jump to its accumulate step.
            prod  <= '0;
            seg   <= (seg < 3'd3) ? 3'd2 : 3'd5;
            state <= S_ACC;
`endif
          end else begin
            seg         <= seg + 3'd1;
            eng_start   <= 1'b1;
            eng_src_idx <= seg_src(1'b1, seg + 3'd1);
            eng_dst_idx <= seg_dst(1'b1, seg + 3'd1);
            state       <= S_LAUNCH;
          end
        end
        S_ACC: begin
          sum  <= sum + prod;
          prod <= {{(PW-1){1'b0}}, 1'b1};
          if (seg == 3'd2) begin
            seg         <= 3'd3;
            eng_start   <= 1'b1;
            eng_src_idx <= seg_src(1'b1, 3'd3);
            eng_dst_idx <= seg_dst(1'b1, 3'd3);
            state       <= S_LAUNCH;
          end else begin
            part2_ans <= sum + prod;
            busy      <= 1'b0;
            done_reg  <= 1'b1;
            state     <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_path_run_sequencer.sv
// Self-checking bench for path_run_sequencer: mocked engine with programmable
// latency, table-driven directed runs, hand-written corner sequences and
// randomized runs checked against a formula-level reference model.
module tb_path_run_sequencer;

  localparam int NW = 10;
  localparam int AW = 24;
  localparam int PW = 49;

  localparam logic [NW-1:0] YOU = 10'h011;
  localparam logic [NW-1:0] SVR = 10'h3A2;
  localparam logic [NW-1:0] OUT = 10'h155;
  localparam logic [NW-1:0] DAC = 10'h0C7;
  localparam logic [NW-1:0] FFT = 10'h2F0;
  localparam logic [AW-1:0] CMAX = {AW{1'b1}};
  localparam logic [AW-1:0] SPUR_VAL = 24'h00F00D;

`ifdef SEG_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef logic [AW-1:0] cnt6_t [6];

  typedef struct {
    bit            p;
    cnt6_t         c;
    logic [AW-1:0] c1;
    int            lat;
    logic [PW-1:0] exp_ans;
    bit            spur;
    bit            poke;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          part_sel;
  logic          start_run;
  logic          eng_start;
  logic [NW-1:0] eng_src_idx;
  logic [NW-1:0] eng_dst_idx;
  logic          eng_done;
  logic [AW-1:0] eng_count;
  logic          busy;
  logic [AW-1:0] part1_ans;
  logic [PW-1:0] part2_ans;
  logic          done_reg;

  path_run_sequencer #(
    .PARAM_NODE_IDX_WIDTH (NW),
    .PARAM_ACCUM_VAL_WIDTH(AW),
    .PARAM_PROD_VAL_WIDTH (PW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .part_sel   (part_sel),
    .start_run  (start_run),
    .cfg_you_idx(YOU),
    .cfg_svr_idx(SVR),
    .cfg_out_idx(OUT),
    .cfg_dac_idx(DAC),
    .cfg_fft_idx(FFT),
    .eng_start  (eng_start),
    .eng_src_idx(eng_src_idx),
    .eng_dst_idx(eng_dst_idx),
    .eng_done   (eng_done),
    .eng_count  (eng_count),
    .busy       (busy),
    .part1_ans  (part1_ans),
    .part2_ans  (part2_ans),
    .done_reg   (done_reg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- mocked engine ----------------
  cnt6_t             cur_counts;
  logic [AW-1:0]     cur_p1;
  int                lat = 2;
  int                spur_cnt = 0, spur_served = 0;
  int                spur_l_cnt = 0, spur_l_served = 0;
  logic [2*NW-1:0]   starts[$];
  int                stab_err = 0;
  int                last_start_cyc = 0, last_done_cyc = 0;
  logic [NW-1:0]     src_h, dst_h;

  function automatic logic [2*NW-1:0] seg_pair(input int s);
    case (s)
      0:       return {SVR, FFT};
      1:       return {FFT, DAC};
      2:       return {DAC, OUT};
      3:       return {SVR, DAC};
      4:       return {DAC, FFT};
      5:       return {FFT, OUT};
      default: return {YOU, OUT};
    endcase
  endfunction

  function automatic logic [AW-1:0] lookup(input logic [NW-1:0] s, input logic [NW-1:0] d);
    if ({s, d} == {YOU, OUT}) return cur_p1;
    for (int i = 0; i < 6; i++)
      if ({s, d} == seg_pair(i)) return cur_counts[i];
    return 24'hBAD000;
  endfunction

  initial begin
    eng_done  = 1'b0;
    eng_count = '0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (spur_cnt != spur_served) begin
        spur_served++;
        eng_done  = 1'b1;
        eng_count = SPUR_VAL;
      end else if (eng_start) begin
        src_h = eng_src_idx;
        dst_h = eng_dst_idx;
        starts.push_back({src_h, dst_h});
        last_start_cyc = cyc;
        if (spur_l_cnt != spur_l_served) begin
          spur_l_served++;
          eng_done  = 1'b1;
          eng_count = SPUR_VAL;
        end
        repeat (lat) begin
          @(negedge clk);
          eng_done = 1'b0;
          if (eng_start) stab_err++;
          if (!rst && busy && (eng_src_idx != src_h || eng_dst_idx != dst_h)) stab_err++;
        end
        eng_done      = 1'b1;
        eng_count     = lookup(src_h, dst_h);
        last_done_cyc = cyc;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [AW-1:0] m_p1 = '0;
  logic [PW-1:0] m_p2 = '0;

  function automatic logic [PW-1:0] part2_model(input cnt6_t c);
    logic [127:0] w;
    w = 128'(c[0]) * 128'(c[1]) * 128'(c[2]) + 128'(c[3]) * 128'(c[4]) * 128'(c[5]);
    return w[PW-1:0];
  endfunction

  task automatic wait_done(input string tag, output int seen_cyc);
    bit ok;
    ok = 1'b0;
    seen_cyc = 0;
    for (int i = 0; i < 500; i++) begin
      if (done_reg) begin
        ok = 1'b1;
        seen_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    check({tag, " done within budget"}, 64'(ok), 64'd1);
  endtask

  task automatic do_run(input string tag, input bit p, input cnt6_t c, input logic [AW-1:0] c1,
                        input int latency, input logic [PW-1:0] exp_ans, input bit spur,
                        input bit poke);
    int              base, sbase, n_exp, req_cyc, seen_cyc;
    bit              ok;
    logic [2*NW-1:0] exp_pair[7];
    logic [2*NW-1:0] got;
    cur_counts = c;
    cur_p1     = c1;
    lat        = latency;
    base       = starts.size();
    sbase      = stab_err;
    if (!p) begin
      exp_pair[0] = {YOU, OUT};
      n_exp       = 1;
      m_p1        = exp_ans;
    end else begin
      n_exp = 0;
      for (int ch = 0; ch < 2; ch++) begin
        for (int k = 0; k < 3; k++) begin
          exp_pair[n_exp] = seg_pair(ch * 3 + k);
          n_exp++;
          if (SKIP && c[ch * 3 + k] == '0 && k < 2) break;
        end
      end
      m_p2 = exp_ans;
    end
    if (spur) spur_l_cnt++;
    @(negedge clk);
    part_sel  = p;
    start_run = 1'b1;
    req_cyc   = cyc;
    @(negedge clk);
    start_run = 1'b0;
    ok = 1'b0;
    seen_cyc = 0;
    for (int i = 0; i < 500; i++) begin
      start_run = (poke && i == 1);
      if (done_reg) begin
        ok = 1'b1;
        seen_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    start_run = 1'b0;
    check({tag, " done within budget"}, 64'(ok), 64'd1);
    if (!p) begin
      check({tag, " start latency"}, 64'(last_start_cyc - req_cyc), 64'd1);
      check({tag, " done latency"}, 64'(seen_cyc - last_done_cyc), 64'd2);
    end
    repeat (2) @(negedge clk);
    check({tag, " done_reg"}, 64'(done_reg), 64'd1);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " part1_ans"}, 64'(part1_ans), 64'(m_p1));
    check({tag, " part2_ans"}, 64'(part2_ans), 64'(m_p2));
    check({tag, " start count"}, 64'(starts.size() - base), 64'(n_exp));
    for (int i = 0; i < n_exp; i++) begin
      got = (base + i < starts.size()) ? starts[base + i] : '1;
      check($sformatf("%s launch %0d src/dst", tag, i), 64'(got), 64'(exp_pair[i]));
    end
    check({tag, " src/dst stable, single pulse"}, 64'(stab_err - sbase), 64'd0);
  endtask

  function automatic vec_t mk(input bit p, input cnt6_t c, input logic [AW-1:0] c1, input int l,
                              input logic [PW-1:0] e, input bit s, input bit k);
    vec_t v;
    v.p = p; v.c = c; v.c1 = c1; v.lat = l; v.exp_ans = e; v.spur = s; v.poke = k;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1);
  end

  initial begin
    vec_t          vecs[7];
    cnt6_t         z, rc;
    int            base, seen;
    bit            ok;
    logic [AW-1:0] r1;

    z = '{default: '0};
    vecs[0] = mk(1'b0, z, 24'd5, 3, 49'd5, 1'b0, 1'b0);
    vecs[1] = mk(1'b1, '{24'd2, 24'd3, 24'd4, 24'd1, 24'd0, 24'd7}, 24'd0, 2, 49'd24, 1'b0, 1'b0);
    vecs[2] = mk(1'b1, '{CMAX, CMAX, CMAX, CMAX, CMAX, CMAX}, 24'd0, 1, 49'h5FFFFFE, 1'b0, 1'b0);
    vecs[3] = mk(1'b1, '{24'd1, 24'd1, 24'd1, 24'd1, 24'd1, 24'd1}, 24'd0, 3, 49'd2, 1'b1, 1'b1);
    vecs[4] = mk(1'b1, '{24'd0, 24'd5, 24'd5, 24'd3, 24'd3, 24'd3}, 24'd0, 2, 49'd27, 1'b0, 1'b0);
    vecs[5] = mk(1'b0, z, 24'd0, 4, 49'd0, 1'b1, 1'b1);
    vecs[6] = mk(1'b0, z, CMAX, 2, 49'(CMAX), 1'b0, 1'b0);

    rst = 1'b1; part_sel = 1'b0; start_run = 1'b0;
    #1;
    check("reset eng_start", 64'(eng_start), 64'd0);
    check("reset src/dst", 64'({eng_src_idx, eng_dst_idx}), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset part1_ans", 64'(part1_ans), 64'd0);
    check("reset part2_ans", 64'(part2_ans), 64'd0);
    check("reset done_reg", 64'(done_reg), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Spurious eng_done while idle.
    spur_cnt++;
    repeat (4) @(negedge clk);
    check("idle spurious done busy", 64'(busy), 64'd0);
    check("idle spurious done done_reg", 64'(done_reg), 64'd0);
    check("idle spurious done starts", 64'(starts.size()), 64'd0);

    // Model cross-check of table constants, then table-driven runs.
    for (int i = 0; i < 7; i++)
      if (vecs[i].p)
        check($sformatf("vec%0d model", i), 64'(part2_model(vecs[i].c)), 64'(vecs[i].exp_ans));
    for (int i = 0; i < 7; i++)
      do_run($sformatf("vec%0d", i), vecs[i].p, vecs[i].c, vecs[i].c1, vecs[i].lat,
             vecs[i].exp_ans, vecs[i].spur, vecs[i].poke);

    // Reset while waiting on segment 3; the late eng_done must be ignored.
    cur_counts = '{24'd1, 24'd2, 24'd3, 24'd4, 24'd5, 24'd6};
    lat  = 6;
    base = starts.size();
    @(negedge clk);
    part_sel = 1'b1; start_run = 1'b1;
    @(negedge clk);
    start_run = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (starts.size() >= base + 4) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("rst test reached seg 3", 64'(ok), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid-run reset eng_start", 64'(eng_start), 64'd0);
    check("mid-run reset src/dst", 64'({eng_src_idx, eng_dst_idx}), 64'd0);
    check("mid-run reset busy", 64'(busy), 64'd0);
    check("mid-run reset answers", 64'(part1_ans) | 64'(part2_ans), 64'd0);
    check("mid-run reset done_reg", 64'(done_reg), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_p1 = '0; m_p2 = '0;
    repeat (12) @(negedge clk);
    check("after reset no extra launch", 64'(starts.size() - base), 64'd4);
    check("after reset busy", 64'(busy), 64'd0);
    check("after reset done_reg", 64'(done_reg), 64'd0);
    check("after reset part2_ans", 64'(part2_ans), 64'd0);
    do_run("post-reset p1", 1'b0, z, 24'd77, 3, 49'd77, 1'b0, 1'b0);

    // Back-to-back: start_run held high across DONE, Part 1 then Part 2.
    cur_counts = '{24'd3, 24'd5, 24'd7, 24'd2, 24'd2, 24'd2};
    cur_p1 = 24'd9;
    lat  = 2;
    base = starts.size();
    @(negedge clk);
    part_sel = 1'b0; start_run = 1'b1;
    @(negedge clk);
    wait_done("b2b p1", seen);
    check("b2b p1 part1_ans", 64'(part1_ans), 64'd9);
    part_sel = 1'b1;
    @(negedge clk);
    start_run = 1'b0;
    check("b2b restart done_reg drops", 64'(done_reg), 64'd0);
    check("b2b restart busy", 64'(busy), 64'd1);
    wait_done("b2b p2", seen);
    m_p1 = 24'd9;
    m_p2 = 49'd113;
    check("b2b p2 part2_ans", 64'(part2_ans), 64'(m_p2));
    check("b2b part1_ans retained", 64'(part1_ans), 64'd9);
    check("b2b launch count", 64'(starts.size() - base), 64'd7);
    repeat (2) @(negedge clk);

    // Randomized runs against the formula model.
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 6; i++) begin
        case ($urandom_range(0, 4))
          0:       rc[i] = '0;
          1:       rc[i] = 24'd1;
          2:       rc[i] = CMAX;
          3:       rc[i] = AW'($urandom_range(0, 1000));
          default: rc[i] = AW'($urandom());
        endcase
      end
      r1 = AW'($urandom());
      if ($urandom_range(0, 1) == 1)
        do_run($sformatf("rand%0d p2", n), 1'b1, rc, r1, int'($urandom_range(1, 5)),
               part2_model(rc), 1'b0, 1'b0);
      else
        do_run($sformatf("rand%0d p1", n), 1'b0, rc, r1, int'($urandom_range(1, 5)),
               49'(r1), 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
